otp_ctrl_ecc_reg_loader: RTL and testbench
==========================================

// Module: otp_ctrl_ecc_reg_loader
// PURPOSE
//  Sequences initial fill of one buffered OTP partition: reads Depth 64-bit words from the OTP macro
//  port, one at a time, and writes each into the ECC-protected partition register file (write port
//  wren/addr/wdata). Sits between the partition controller and the macro arbiter. Reports completion,
//  OTP read errors and protocol errors; optionally watches the register file's concurrent ECC error.
// PARAMETERS
//  Depth     16  number of 64-bit words in the partition (>=1)
//  OtpAw     11  OTP macro word-address width
//  BaseAddr  0   OTP word address of partition word 0; BaseAddr+Depth-1 must fit in OtpAw
//  Aw        -   localparam = prim_util_pkg::vbits(Depth)
// PORTS
//  clk_i         in   1      clock
//  rst_i         in   1      reset, asynchronous, active-high
//  init_req_i    in   1      start fill; sampled only in Idle
//  init_done_o   out  1      partition fully loaded; sticky until reset
//  busy_o        out  1      FSM not in Idle/Done/Error
//  error_o       out  1      FSM in Error; sticky until reset
//  err_code_o    out  2      00 none, 01 OTP read err, 10 ECC err, 11 protocol err
//  otp_req_o     out  1      read request to macro arbiter
//  otp_addr_o    out  OtpAw  read word address, valid while otp_req_o
//  otp_gnt_i     in   1      request accepted this cycle
//  otp_rvalid_i  in   1      read response valid
//  otp_rdata_i   in   64     read data
//  otp_err_i     in   1      read response carries uncorrectable error (qualified by rvalid)
//  reg_wren_o    out  1      register-file write enable
//  reg_addr_o    out  Aw     register-file word address
//  reg_wdata_o   out  64     register-file write data
//  reg_ecc_err_i in   1      concurrent ECC error from register file
// BEHAVIOUR
//  Reset: all outputs 0; FSM=Idle; word counter cnt=0; data buffer=0. Register-file contents untouched.
//  Idle:    init_req_i=1 -> ReqWait, cnt=0. Otherwise stay.
//  ReqWait: otp_req_o=1, otp_addr_o=BaseAddr+cnt (zero-extended to OtpAw). Held stable until
//           otp_gnt_i; on gnt -> RspWait. rvalid here -> Error(11).
//  RspWait: one read outstanding. rvalid&!otp_err_i -> buffer rdata, -> Write.
//           rvalid&otp_err_i -> Error(01), no write. Unbounded wait (no timeout).
//  Write:   reg_wren_o=1 one cycle, reg_addr_o=cnt, reg_wdata_o=buffer.
//           cnt==Depth-1 -> Done; else cnt++ -> ReqWait. rvalid here -> Error(11).
//  Done:    init_done_o=1; init_req_i ignored; terminal until reset.
//  Error:   error_o=1, err_code_o holds first cause; all req/wren 0; terminal until reset.
//  Latency: min 3 cycles/word (gnt same cycle as req, rvalid next cycle); Depth=16 -> done asserted
//           48 cycles after the init_req_i cycle. Exactly one reg_wren_o pulse per word, addresses 0..Depth-1 in order.
//  reg_addr_o/reg_wdata_o are 0 whenever reg_wren_o=0. cnt never exceeds Depth-1 (no wrap).
//  Reset mid-fill: immediate return to Idle; partial contents stay; a late rvalid after reset in Idle is ignored.
//  Simultaneous error sources: OTP err takes priority over ECC err in the same cycle.
// CONFIGURATION
//  Macro OTP_CTRL_ECC_REG_LOADER_ECC_CHECK_EN:
//   defined: reg_ecc_err_i=1 in Write (cycle after write) or Done -> Error(10), init_done_o drops to 0.
//   undefined: reg_ecc_err_i ignored; code 10 unreachable; port kept for uniform instantiation.
// STRUCTURE
//  otp_ctrl_pkg: loader_state_e (6 states, one-hot-safe sparse encoding, 6 bits) and
//   loader_err_e (2-bit codes above).
//  Single module, no sub-module; counter, FSM and 64-bit buffer are local. Parent instantiates the
//   register file and connects reg_* ports to it.
// TESTING
//  1 Depth=16, BaseAddr=0x40, gnt immediate, rvalid+1, data=addr*0x0101 -> 16 writes addr 0..15, done at cycle 48.
//  2 Random gnt delay 0-5, rvalid delay 1-7 -> otp_addr stable while req; write order/data correct; done sticky.
//  3 otp_err_i on word 5 -> error_o=1, err_code=01, only words 0..4 written, req stays 0 afterwards.
//  4 Spurious rvalid in ReqWait at word 3 -> Error(11); with CHECK_EN, reg_ecc_err_i pulse in Done -> Error(10), done=0.
//  5 rst_i asserted during RspWait of word 7 -> all outputs 0 next cycle; new init_req refills from word 0.
//  6 Depth=1 -> single req to BaseAddr, one write to addr 0, done after 3 cycles; init_req in Done ignored.

Source files
------------

// File: rtl/otp_ctrl_ecc_reg_loader_pkg.sv
// -----------------------------------------------------------------------------
// otp_ctrl_ecc_reg_loader_pkg
// Shared types for the OTP partition register loader:
//   loader_state_e : FSM states, sparse one-hot encoding (6 bits)
//   loader_err_e   : 2-bit error cause codes reported on err_code_o
//   vbits()        : address width needed to index a given number of words
// -----------------------------------------------------------------------------
package otp_ctrl_ecc_reg_loader_pkg;

    typedef enum logic [5:0] {
        StIdle    = 6'b000001,
        StReqWait = 6'b000010,
        StRspWait = 6'b000100,
        StWrite   = 6'b001000,
        StDone    = 6'b010000,
        StError   = 6'b100000
    } loader_state_e;

    typedef enum logic [1:0] {
        ErrNone  = 2'b00,
        ErrOtp   = 2'b01,
        ErrEcc   = 2'b10,
        ErrProto = 2'b11
    } loader_err_e;

    // A single-word partition still needs a 1-bit address.
    function automatic int unsigned vbits(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/otp_ctrl_ecc_reg_loader.sv
// -----------------------------------------------------------------------------
// otp_ctrl_ecc_reg_loader
// Fills one buffered OTP partition: reads Depth 64-bit words from the OTP
// macro port one at a time and writes each into the partition register file.
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   init_req_i                 start fill (sampled only in Idle)
//   init_done_o                partition fully loaded (sticky)
//   busy_o                     fill in progress
//   error_o / err_code_o       terminal error and its first cause
//   otp_req_o / otp_addr_o     read request and word address to arbiter
//   otp_gnt_i                  request accepted
//   otp_rvalid_i / otp_rdata_i / otp_err_i   read response
//   reg_wren_o / reg_addr_o / reg_wdata_o    register-file write port
//   reg_ecc_err_i              register-file concurrent ECC error
//
// Configuration macro OTP_CTRL_ECC_REG_LOADER_ECC_CHECK_EN: when defined,
// reg_ecc_err_i in Write or Done moves the FSM to Error with code 10.
// When undefined the input is ignored.
// -----------------------------------------------------------------------------
module otp_ctrl_ecc_reg_loader
    import otp_ctrl_ecc_reg_loader_pkg::*;
#(
    parameter int unsigned Depth    = 16,
    parameter int unsigned OtpAw    = 11,
    parameter int unsigned BaseAddr = 0,
    localparam int unsigned Aw      = vbits(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             init_req_i,
    output logic             init_done_o,
    output logic             busy_o,
    output logic             error_o,
    output logic [1:0]       err_code_o,
    output logic             otp_req_o,
    output logic [OtpAw-1:0] otp_addr_o,
    input  logic             otp_gnt_i,
    input  logic             otp_rvalid_i,
    input  logic [63:0]      otp_rdata_i,
    input  logic             otp_err_i,
    output logic             reg_wren_o,
    output logic [Aw-1:0]    reg_addr_o,
    output logic [63:0]      reg_wdata_o,
    input  logic             reg_ecc_err_i
);

    localparam logic [Aw-1:0] LastIdx = Aw'(Depth - 1);

    loader_state_e state_q, state_d;
    loader_err_e   err_q, err_d;
    logic [Aw-1:0] cnt_q, cnt_d;
    logic [63:0]   buf_q, buf_d;

`ifndef OTP_CTRL_ECC_REG_LOADER_ECC_CHECK_EN
    logic unused_ecc_err;
    assign unused_ecc_err = reg_ecc_err_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            err_q   <= ErrNone;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        init_done_o = 1'b0;
        busy_o      = 1'b0;
        error_o     = 1'b0;
        otp_req_o   = 1'b0;
        otp_addr_o  = '0;
        reg_wren_o  = 1'b0;
        reg_addr_o  = '0;
        reg_wdata_o = '0;
        // err_q only leaves ErrNone on entry to Error, so it can drive the port directly.
        err_code_o  = err_q;

        unique case (state_q)
            StIdle: begin
                if (init_req_i) begin
                    state_d = StReqWait;
                    cnt_d   = '0;
                end
            end

            StReqWait: begin
                busy_o     = 1'b1;
                otp_req_o  = 1'b1;
                otp_addr_o = OtpAw'(BaseAddr) + OtpAw'(cnt_q);
                // A response with nothing outstanding is a protocol violation,
                // even if the grant arrives in the same cycle.
                if (otp_rvalid_i) begin
                    state_d = StError;
                    err_d   = ErrProto;
                end else if (otp_gnt_i) begin
                    state_d = StRspWait;
                end
            end

            StRspWait: begin
                busy_o = 1'b1;
                if (otp_rvalid_i) begin
                    if (otp_err_i) begin
                        state_d = StError;
                        err_d   = ErrOtp;
                    end else begin
                        buf_d   = otp_rdata_i;
                        state_d = StWrite;
                    end
                end
            end

            StWrite: begin
                busy_o      = 1'b1;
                reg_wren_o  = 1'b1;
                reg_addr_o  = cnt_q;
                reg_wdata_o = buf_q;
                // OTP-side faults outrank a register-file ECC error in the same cycle.
                if (otp_rvalid_i) begin
                    state_d = StError;
                    err_d   = ErrProto;
`ifdef OTP_CTRL_ECC_REG_LOADER_ECC_CHECK_EN
                end else if (reg_ecc_err_i) begin
                    state_d = StError;
                    err_d   = ErrEcc;
`endif
                end else if (cnt_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    cnt_d   = cnt_q + Aw'(1);
                    state_d = StReqWait;
                end
            end

            StDone: begin
                init_done_o = 1'b1;
`ifdef OTP_CTRL_ECC_REG_LOADER_ECC_CHECK_EN
                if (reg_ecc_err_i) begin
                    init_done_o = 1'b0;
                    state_d     = StError;
                    err_d       = ErrEcc;
                end
`endif
            end

            StError: begin
                error_o = 1'b1;
            end

            default: begin
                state_d = StError;
                err_d   = ErrProto;
            end
        endcase
    end

endmodule

// File: tb/tb_otp_ctrl_ecc_reg_loader.sv
module tb_otp_ctrl_ecc_reg_loader;

  localparam int unsigned BASE = 'h40;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  logic        init_req = 1'b0;
  logic        done, busy, error;
  logic [1:0]  err_code;
  logic        otp_req;
  logic [10:0] otp_addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [63:0] rdata = '0;
  logic        otp_err = 1'b0;
  logic        wren;
  logic [3:0]  reg_addr;
  logic [63:0] wdata;
  logic        ecc_err = 1'b0;

  otp_ctrl_ecc_reg_loader #(.Depth(16), .OtpAw(11), .BaseAddr(BASE)) dut (
    .clk_i(clk), .rst_i(rst), .init_req_i(init_req), .init_done_o(done),
    .busy_o(busy), .error_o(error), .err_code_o(err_code),
    .otp_req_o(otp_req), .otp_addr_o(otp_addr), .otp_gnt_i(gnt),
    .otp_rvalid_i(rvalid), .otp_rdata_i(rdata), .otp_err_i(otp_err),
    .reg_wren_o(wren), .reg_addr_o(reg_addr), .reg_wdata_o(wdata),
    .reg_ecc_err_i(ecc_err)
  );

  logic        s_init_req = 1'b0;
  logic        s_done, s_busy, s_error;
  logic [1:0]  s_err_code;
  logic        s_req;
  logic [10:0] s_addr;
  logic        s_gnt = 1'b0;
  logic        s_rvalid = 1'b0;
  logic [63:0] s_rdata = '0;
  logic        s_wren;
  logic [0:0]  s_reg_addr;
  logic [63:0] s_wdata;

  otp_ctrl_ecc_reg_loader #(.Depth(1), .OtpAw(11), .BaseAddr(2047)) dut1 (
    .clk_i(clk), .rst_i(rst), .init_req_i(s_init_req), .init_done_o(s_done),
    .busy_o(s_busy), .error_o(s_error), .err_code_o(s_err_code),
    .otp_req_o(s_req), .otp_addr_o(s_addr), .otp_gnt_i(s_gnt),
    .otp_rvalid_i(s_rvalid), .otp_rdata_i(s_rdata), .otp_err_i(1'b0),
    .reg_wren_o(s_wren), .reg_addr_o(s_reg_addr), .reg_wdata_o(s_wdata),
    .reg_ecc_err_i(1'b0)
  );

  int unsigned wr_count     = 0;
  int unsigned idle_nonzero = 0;
  always @(negedge clk) begin
    if (wren) wr_count++;
    else if (reg_addr !== '0 || wdata !== '0) idle_nonzero++;
  end

  logic [63:0] exp_data [16];

  task automatic check(input string tag, input bit ok, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic start_fill();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
  endtask

  task automatic serve_word(input int k, input int gd, input int rd, input bit bad);
    check("otp_req", otp_req === 1'b1, otp_req, 1'b1);
    check("otp_addr", otp_addr === 11'(BASE + k), otp_addr, 11'(BASE + k));
    for (int i = 0; i < gd; i++) begin
      tick();
      check("req_hold", otp_req === 1'b1, otp_req, 1'b1);
      check("addr_hold", otp_addr === 11'(BASE + k), otp_addr, 11'(BASE + k));
    end
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    check("req_after_gnt", otp_req === 1'b0, otp_req, 1'b0);
    for (int i = 1; i < rd; i++) tick();
    rvalid  = 1'b1;
    rdata   = exp_data[k];
    otp_err = bad;
    tick();
    rvalid  = 1'b0;
    otp_err = 1'b0;
    rdata   = '0;
    if (!bad) begin
      check("wren", wren === 1'b1, wren, 1'b1);
      check("reg_addr", reg_addr === 4'(k), reg_addr, 4'(k));
      check("reg_wdata", wdata === exp_data[k], wdata, exp_data[k]);
      tick();
    end
  endtask

  task automatic fill_pattern();
    for (int k = 0; k < 16; k++) exp_data[k] = 64'(BASE + k) * 64'h0101;
  endtask

  initial begin
    int unsigned c0;
    int unsigned wr0;

    tick();
    check("rst_done", done === 1'b0, done, 1'b0);
    check("rst_busy", busy === 1'b0, busy, 1'b0);
    check("rst_error", error === 1'b0, error, 1'b0);
    check("rst_code", err_code === 2'b00, err_code, 2'b00);
    check("rst_req", otp_req === 1'b0, otp_req, 1'b0);
    check("rst_wren", wren === 1'b0, wren, 1'b0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy === 1'b0, busy, 1'b0);
    check("idle_addr", otp_addr === 11'h000, otp_addr, 11'h000);

    fill_pattern();
    wr0 = wr_count;
    start_fill();
    c0 = cyc;
    check("busy_fill", busy === 1'b1, busy, 1'b1);
    for (int k = 0; k < 15; k++) serve_word(k, 0, 1, 1'b0);
    check("done_before_last", done === 1'b0, done, 1'b0);
    serve_word(15, 0, 1, 1'b0);
    check("done_t1", done === 1'b1, done, 1'b1);
    check("done_latency", (cyc - c0) === 32'd48, cyc - c0, 32'd48);
    check("busy_done", busy === 1'b0, busy, 1'b0);
    check("writes_t1", (wr_count - wr0) === 32'd16, wr_count - wr0, 32'd16);

    do_reset();
    for (int k = 0; k < 16; k++) exp_data[k] = {$urandom, $urandom};
    wr0 = wr_count;
    start_fill();
    for (int k = 0; k < 16; k++)
      serve_word(k, int'($urandom_range(0, 5)), int'($urandom_range(1, 7)), 1'b0);
    check("done_t2", done === 1'b1, done, 1'b1);
    check("writes_t2", (wr_count - wr0) === 32'd16, wr_count - wr0, 32'd16);
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    tick();
    tick();
    check("done_sticky", done === 1'b1, done, 1'b1);
    check("done_no_req", otp_req === 1'b0, otp_req, 1'b0);
    check("done_no_busy", busy === 1'b0, busy, 1'b0);

    do_reset();
    fill_pattern();
    wr0 = wr_count;
    start_fill();
    for (int k = 0; k < 5; k++) serve_word(k, int'($urandom_range(0, 2)), 1, 1'b0);
    serve_word(5, 0, int'($urandom_range(1, 4)), 1'b1);
    check("otp_err_flag", error === 1'b1, error, 1'b1);
    check("otp_err_code", err_code === 2'b01, err_code, 2'b01);
    check("otp_err_wren", wren === 1'b0, wren, 1'b0);
    check("otp_err_done", done === 1'b0, done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("err_req_low", otp_req === 1'b0, otp_req, 1'b0);
    end
    check("writes_t3", (wr_count - wr0) === 32'd5, wr_count - wr0, 32'd5);

    do_reset();
    start_fill();
    for (int k = 0; k < 3; k++) serve_word(k, 0, 1, 1'b0);
    check("t4_req_w3", otp_req === 1'b1, otp_req, 1'b1);
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    check("proto_flag", error === 1'b1, error, 1'b1);
    check("proto_code", err_code === 2'b11, err_code, 2'b11);
    check("proto_req", otp_req === 1'b0, otp_req, 1'b0);
    check("proto_busy", busy === 1'b0, busy, 1'b0);

    do_reset();
    start_fill();
    for (int k = 0; k < 16; k++) serve_word(k, 0, 1, 1'b0);
    check("t4_done", done === 1'b1, done, 1'b1);
    ecc_err = 1'b1;
    tick();
    ecc_err = 1'b0;
`ifdef OTP_CTRL_ECC_REG_LOADER_ECC_CHECK_EN
    check("ecc_flag", error === 1'b1, error, 1'b1);
    check("ecc_code", err_code === 2'b10, err_code, 2'b10);
    check("ecc_done", done === 1'b0, done, 1'b0);
`else
    check("ecc_ignored_flag", error === 1'b0, error, 1'b0);
    check("ecc_ignored_code", err_code === 2'b00, err_code, 2'b00);
    check("ecc_ignored_done", done === 1'b1, done, 1'b1);
`endif

    do_reset();
    wr0 = wr_count;
    start_fill();
    for (int k = 0; k < 7; k++) serve_word(k, 0, 1, 1'b0);
    check("t5_addr_w7", otp_addr === 11'(BASE + 7), otp_addr, 11'(BASE + 7));
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    check("t5_busy_rsp", busy === 1'b1, busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy === 1'b0, busy, 1'b0);
    check("mid_rst_req", otp_req === 1'b0, otp_req, 1'b0);
    check("mid_rst_wren", wren === 1'b0, wren, 1'b0);
    tick();
    check("mid_rst_done", done === 1'b0, done, 1'b0);
    check("mid_rst_error", error === 1'b0, error, 1'b0);
    rst = 1'b0;
    rvalid = 1'b1;
    rdata  = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    rvalid = 1'b0;
    rdata  = '0;
    tick();
    check("late_rvalid_busy", busy === 1'b0, busy, 1'b0);
    check("late_rvalid_error", error === 1'b0, error, 1'b0);
    check("late_rvalid_wren", wren === 1'b0, wren, 1'b0);
    start_fill();
    for (int k = 0; k < 16; k++) serve_word(k, 0, 1, 1'b0);
    check("refill_done", done === 1'b1, done, 1'b1);
    check("writes_t5", (wr_count - wr0) === 32'd23, wr_count - wr0, 32'd23);

    s_init_req = 1'b1;
    tick();
    s_init_req = 1'b0;
    c0 = cyc;
    check("s_req", s_req === 1'b1, s_req, 1'b1);
    check("s_addr", s_addr === 11'h7FF, s_addr, 11'h7FF);
    s_gnt = 1'b1;
    tick();
    s_gnt = 1'b0;
    s_rvalid = 1'b1;
    s_rdata  = 64'h0123_4567_89AB_CDEF;
    tick();
    s_rvalid = 1'b0;
    s_rdata  = '0;
    check("s_wren", s_wren === 1'b1, s_wren, 1'b1);
    check("s_reg_addr", s_reg_addr === 1'b0, s_reg_addr, 1'b0);
    check("s_wdata", s_wdata === 64'h0123_4567_89AB_CDEF, s_wdata, 64'h0123_4567_89AB_CDEF);
    check("s_done_early", s_done === 1'b0, s_done, 1'b0);
    tick();
    check("s_done", s_done === 1'b1, s_done, 1'b1);
    check("s_latency", (cyc - c0) === 32'd3, cyc - c0, 32'd3);
    s_init_req = 1'b1;
    tick();
    s_init_req = 1'b0;
    tick();
    check("s_done_sticky", s_done === 1'b1, s_done, 1'b1);
    check("s_no_req", s_req === 1'b0, s_req, 1'b0);
    check("s_no_busy", s_busy === 1'b0, s_busy, 1'b0);

    check("idle_write_port_zero", idle_nonzero === 32'd0, idle_nonzero, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
